// File: rtl/cached_mem_stage.sv
// Pipeline MEM stage with a direct-mapped, write-through, no-write-allocate cache
// in front of a handshake backing memory; also resolves branch pcSrc.
module cached_mem_stage #(
  parameter  int DATA_W = 32,
  parameter  int LINES  = 16,
  localparam int IDX_W  = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zero,
  input  logic              branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] aluRslt,
  input  logic [DATA_W-1:0] datafrmreg,
  output logic              hit,
  output logic              pcSrc,
  output logic              stall,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] aluRsltt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TAG_W = DATA_W - IDX_W - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [DATA_W-1:0] lineData_q [LINES];
  logic [TAG_W-1:0]  lineTag_q  [LINES];

  logic              memReq_q, memWe_q;
  logic [DATA_W-1:0] memAddr_q, memWdata_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              lineHit;
  logic              lookupState;
  logic              fillDone;
  logic              writeDone;

  assign idx         = aluRslt[IDX_W+1:2];
  assign tag         = aluRslt[DATA_W-1:IDX_W+2];
  assign lineHit     = valid_q[idx] && (lineTag_q[idx] == tag);
  assign lookupState = (state_q == IDLE) || (state_q == DONE);
  assign fillDone    = (state_q == FILL) && mem_ack;
  assign writeDone   = (state_q == WRITE) && mem_ack;

  assign pcSrc     = branch & zero;
  assign aluRsltt  = aluRslt;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;

  // A simultaneous read and write is handled as a write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (MemWrite)                state_d = WRITE;
        else if (MemRead && !lineHit) state_d = FILL;
      end
      FILL:    if (mem_ack) state_d = DONE;
      WRITE:   if (mem_ack) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit      = lookupState && lineHit && (MemRead || MemWrite);
    stall    = 1'b0;
    readdata = '0;
    case (state_q)
      IDLE:        stall = MemWrite || (MemRead && !lineHit);
      FILL, WRITE: stall = 1'b1;
      default:     stall = 1'b0;
    endcase
    if (lookupState && MemRead && !MemWrite && lineHit)
      readdata = lineData_q[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (fillDone)
        valid_q[idx] <= 1'b1;
      // Request registers launch on the IDLE exit edge so they are live from the first FILL/WRITE cycle.
      if (state_q == IDLE && state_d == FILL) begin
        memReq_q   <= 1'b1;
        memWe_q    <= 1'b0;
        memAddr_q  <= {aluRslt[DATA_W-1:2], 2'b00};
        memWdata_q <= '0;
      end else if (state_q == IDLE && state_d == WRITE) begin
        memReq_q   <= 1'b1;
        memWe_q    <= 1'b1;
        memAddr_q  <= {aluRslt[DATA_W-1:2], 2'b00};
        memWdata_q <= datafrmreg;
      end else if (fillDone || writeDone) begin
        memReq_q <= 1'b0;
        memWe_q  <= 1'b0;
      end
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fillDone) begin
        lineData_q[idx] <= mem_rdata;
        lineTag_q[idx]  <= tag;
      end else if (writeDone && lineHit) begin
        lineData_q[idx] <= datafrmreg;
      end
    end
  end

endmodule
